// File: rtl/if_id_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its IF/ID register.
package if_id_stage_pkg;

    // Datapath word and byte-address widths.
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    // All-zero word is sll $0,$0,0, used as the bubble instruction.
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch advances by one word.
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

endpackage

// File: rtl/if_id_stage_imem_rom.sv
// Word-addressed instruction memory: synchronous write for program load,
// asynchronous read for fetch. Contents are never cleared by reset.
module if_id_stage_imem_rom
    import if_id_stage_pkg::*;
#(
    parameter int WORDS = 64,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [WORDS];

    // Program-load write port; the async read below sees the old word until this edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage of the MIPS pipeline: program counter, instruction memory and
// the IF/ID pipeline register with stall, flush and branch/jump redirect.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              imem_we_i,
    input  logic [ADDR_W-1:0] imem_waddr_i,
    input  logic [WORD_W-1:0] imem_wdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [WORD_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0] if_id_pc4_o,
    output logic [15:0]       if_id_imm_o,
    output logic              if_id_valid_o,
    output logic [31:0]       fetch_count_o
);

    localparam int IDX = $clog2(IMEM_WORDS);

    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q,   pc4_d;
    logic [15:0]       imm_q,   imm_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;

    logic [WORD_W-1:0] fetch_word;
    logic [ADDR_W-1:0] pc_plus4;

    // Byte-offset and above-depth address bits play no part in indexing.
    logic unused_waddr_bits;
    assign unused_waddr_bits = ^{imem_waddr_i[ADDR_W-1:IDX+2], imem_waddr_i[1:0]};

    if_id_stage_imem_rom #(
        .WORDS (IMEM_WORDS),
        .IDX_W (IDX)
    ) u_imem (
        .clk     (clk),
        .we_i    (imem_we_i),
        .waddr_i (imem_waddr_i[IDX+1:2]),
        .wdata_i (imem_wdata_i),
        .raddr_i (pc_q[IDX+1:2]),
        .rdata_o (fetch_word)
    );

    assign pc_plus4 = pc_q + PC_STEP;

    // Next PC and IF/ID contents: redirect beats stall, flush/redirect beats stall for IF/ID.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        count_d = count_q;

        if (branch_taken_i) begin
            pc_d = branch_target_i;
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end

        if (branch_taken_i || flush_i) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            imm_d   = '0;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d = fetch_word;
            pc4_d   = pc_plus4;
            imm_d   = fetch_word[15:0];
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // PC and IF/ID state registers; reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign pc_o          = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_imm_o   = imm_q;
    assign if_id_valid_o = valid_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, async-reset and
// read-before-write sequences, then randomized traffic against a reference model.
module tb_if_id_stage;

    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, br, we;
    logic [31:0] target, waddr, wdata;
    logic [31:0] pc, instr, pc4, count;
    logic [15:0] imm;
    logic        valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem [WORDS];

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [20];

    if_id_stage #(
        .IMEM_WORDS (WORDS),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_taken_i  (br),
        .branch_target_i (target),
        .imem_we_i       (we),
        .imem_waddr_i    (waddr),
        .imem_wdata_i    (wdata),
        .pc_o            (pc),
        .if_id_instr_o   (instr),
        .if_id_pc4_o     (pc4),
        .if_id_imm_o     (imm),
        .if_id_valid_o   (valid),
        .fetch_count_o   (count)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
        check32({tag, ".pc"},    pc,            e_pc);
        check32({tag, ".instr"}, instr,         e_instr);
        check32({tag, ".imm"},   {16'h0, imm},  {16'h0, e_instr[15:0]});
        check32({tag, ".pc4"},   pc4,           e_pc4);
        check32({tag, ".valid"}, {31'h0, valid}, {31'h0, e_valid});
        check32({tag, ".count"}, count,         e_cnt);
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; br = 0; target = 0; we = 0; waddr = 0; wdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized phase.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    initial begin
        clear_inputs();
        rst = 1'b1;

        for (int i = 0; i < WORDS; i++) tb_mem[i] = 32'hA000_0000 | i;
        tb_mem[0] = 32'h8C01_0004;
        tb_mem[1] = 32'h2022_FFFF;
        tb_mem[2] = 32'h0000_0000;
        tb_mem[3] = 32'h1000_FFFD;

        //            stall flush br target        pc            instr         pc4          v  cnt
        vecs[0]  = '{0, 0, 0, 32'h0,         32'h4,        32'h8C010004, 32'h4,       1, 1};
        vecs[1]  = '{0, 0, 0, 32'h0,         32'h8,        32'h2022FFFF, 32'h8,       1, 2};
        vecs[2]  = '{1, 0, 0, 32'h0,         32'h8,        32'h2022FFFF, 32'h8,       1, 2};
        vecs[3]  = '{1, 0, 0, 32'h0,         32'h8,        32'h2022FFFF, 32'h8,       1, 2};
        vecs[4]  = '{1, 0, 0, 32'h0,         32'h8,        32'h2022FFFF, 32'h8,       1, 2};
        vecs[5]  = '{0, 0, 0, 32'h0,         32'hC,        32'h00000000, 32'hC,       1, 3};
        vecs[6]  = '{0, 0, 1, 32'h10,        32'h10,       32'h00000000, 32'h0,       0, 3};
        vecs[7]  = '{0, 0, 0, 32'h0,         32'h14,       32'hA0000004, 32'h14,      1, 4};
        vecs[8]  = '{1, 0, 1, 32'h20,        32'h20,       32'h00000000, 32'h0,       0, 4};
        vecs[9]  = '{0, 0, 0, 32'h0,         32'h24,       32'hA0000008, 32'h24,      1, 5};
        vecs[10] = '{1, 1, 0, 32'h0,         32'h24,       32'h00000000, 32'h0,       0, 5};
        vecs[11] = '{0, 0, 0, 32'h0,         32'h28,       32'hA0000009, 32'h28,      1, 6};
        vecs[12] = '{0, 0, 1, 32'hFC,        32'hFC,       32'h00000000, 32'h0,       0, 6};
        vecs[13] = '{0, 0, 0, 32'h0,         32'h100,      32'hA000003F, 32'h100,     1, 7};
        vecs[14] = '{0, 0, 0, 32'h0,         32'h104,      32'h8C010004, 32'h104,     1, 8};
        vecs[15] = '{0, 0, 1, 32'hFFFFFFFC,  32'hFFFFFFFC, 32'h00000000, 32'h0,       0, 8};
        vecs[16] = '{0, 0, 0, 32'h0,         32'h0,        32'hA000003F, 32'h0,       1, 9};
        vecs[17] = '{0, 0, 0, 32'h0,         32'h4,        32'h8C010004, 32'h4,       1, 10};
        vecs[18] = '{0, 1, 0, 32'h0,         32'h8,        32'h00000000, 32'h0,       0, 10};
        vecs[19] = '{0, 0, 0, 32'h0,         32'hC,        32'h00000000, 32'hC,       1, 11};

        // Program load while reset is held; memory is not affected by reset.
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < WORDS; i++) begin
            we = 1; waddr = i * 4; wdata = tb_mem[i];
            step();
        end
        clear_inputs();
        check_all("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;

        // Directed vector table.
        for (int v = 0; v < 20; v++) begin
            stall = vecs[v].stall; flush = vecs[v].flush; br = vecs[v].br; target = vecs[v].target;
            step();
            clear_inputs();
            $display("vec %0d: pc=%08h instr=%08h pc4=%08h valid=%0b cnt=%0d", v, pc, instr, pc4, valid, count);
            check_all($sformatf("vec%0d", v), vecs[v].exp_pc, vecs[v].exp_instr,
                      vecs[v].exp_pc4, vecs[v].exp_valid, vecs[v].exp_cnt);
        end

        // Async reset between edges while IF/ID holds a valid instruction.
        #3;
        rst = 1'b1;
        #1;
        $display("async reset: pc=%08h valid=%0b cnt=%0d", pc, valid, count);
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        step();
        $display("post-reset fetch: pc=%08h instr=%08h cnt=%0d", pc, instr, count);
        check_all("rst_resume", 32'h4, 32'h8C010004, 32'h4, 1'b1, 32'h1);

        // Write to the word being fetched: fetch sees the old data, later refetch sees new.
        we = 1; waddr = 32'h4; wdata = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        tb_mem[1] = 32'hDEAD_BEEF;
        $display("rbw fetch: instr=%08h", instr);
        check_all("rbw_old", 32'h8, 32'h2022FFFF, 32'h8, 1'b1, 32'h2);
        br = 1; target = 32'h4;
        step();
        clear_inputs();
        step();
        $display("rbw refetch: instr=%08h", instr);
        check_all("rbw_new", 32'h8, 32'hDEADBEEF, 32'h8, 1'b1, 32'h3);

        // Randomized traffic against the reference model, from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            logic [31:0] fetched;
            stall  = ($urandom_range(0, 99) < 25);
            flush  = ($urandom_range(0, 99) < 10);
            br     = ($urandom_range(0, 99) < 10);
            target = $urandom();
            we     = ($urandom_range(0, 99) < 20);
            waddr  = ($urandom_range(0, 1) == 0) ? m_pc : $urandom();
            wdata  = $urandom();

            fetched = tb_mem[(m_pc / 4) % WORDS];
            if (br || flush) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!stall) begin
                m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            end
            if (br) m_pc = target;
            else if (!stall) m_pc = m_pc + 4;
            if (we) tb_mem[(waddr / 4) % WORDS] = wdata;

            step();
            $display("rand %0d: st=%0b fl=%0b br=%0b we=%0b pc=%08h instr=%08h valid=%0b cnt=%0d",
                     c, stall, flush, br, we, pc, instr, valid, count);
            clear_inputs();
            check_all($sformatf("rand%0d", c), m_pc, m_instr, m_pc4, m_valid, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
